// File: rtl/adder_result_checker.sv
// Receiving-end checker for a registered WIDTH-bit adder: computes the golden
// {carryout, sum}, delays it by the adder latency and compares against the adder.
module adder_result_checker #(
   parameter int WIDTH       = 4,
   parameter int LATENCY     = 1,
   parameter int CNT_W       = 8,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             carryin,
   input  logic [WIDTH-1:0] sum,
   input  logic             carryout,
   output logic [WIDTH-1:0] exp_sum,
   output logic             exp_cout,
   output logic             chk_valid,
   output logic             mismatch,
   output logic             err_sticky,
   output logic [CNT_W-1:0] check_count,
   output logic [CNT_W-1:0] err_count,
   output logic             busy
);

   // state    | meaning
   // S_IDLE   | disarmed, no comparisons
   // S_FILL   | armed, waiting for post-arm operands to reach the last stage
   // S_CHECK  | comparing every valid last-stage entry against the adder
   // S_HALT   | stopped on first mismatch, counters frozen until clear/rst
   typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_HALT} state_t;

   localparam int FW = 3;

   state_t           state_q, state_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic [CNT_W-1:0] chk_cnt_q, chk_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             sticky_q, sticky_d;

   logic [LATENCY-1:0] vld_q;
   logic [WIDTH:0]     gold_q [LATENCY];
   logic [WIDTH:0]     gold_in;
   logic [WIDTH:0]     gold_last;

   assign gold_in   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, carryin};
   assign gold_last = gold_q[LATENCY-1];

   // The delay line runs in every state; clear deliberately leaves it alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int k = 0; k < LATENCY; k++) gold_q[k] <= '0;
      end else begin
         vld_q[0]  <= in_valid;
         gold_q[0] <= gold_in;
         for (int k = 1; k < LATENCY; k++) begin
            vld_q[k]  <= vld_q[k-1];
            gold_q[k] <= gold_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         fill_q    <= '0;
         chk_cnt_q <= '0;
         err_cnt_q <= '0;
         sticky_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         chk_cnt_q <= chk_cnt_d;
         err_cnt_q <= err_cnt_d;
         sticky_q  <= sticky_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      chk_cnt_d = chk_cnt_q;
      err_cnt_d = err_cnt_q;
      sticky_d  = sticky_q;
      chk_valid = 1'b0;
      mismatch  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FILL;
               fill_d  = FW'(LATENCY - 1);
            end
         end
         S_FILL: begin
            if (fill_q == '0) state_d = S_CHECK;
            else              fill_d  = fill_q - 1'b1;
         end
         S_CHECK: begin
            if (vld_q[LATENCY-1]) begin
               chk_valid = 1'b1;
               if (chk_cnt_q != '1) chk_cnt_d = chk_cnt_q + 1'b1;
               if ({carryout, sum} != gold_last) begin
                  mismatch = 1'b1;
                  sticky_d = 1'b1;
                  if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                  if (STOP_ON_ERR) state_d = S_HALT;
               end
            end
         end
         default: ;
      endcase

      // clear overrides any arming or comparison in the same cycle
      if (clear) begin
         state_d   = S_IDLE;
         fill_d    = '0;
         chk_cnt_d = '0;
         err_cnt_d = '0;
         sticky_d  = 1'b0;
         chk_valid = 1'b0;
         mismatch  = 1'b0;
      end
   end

   assign exp_sum     = gold_last[WIDTH-1:0];
   assign exp_cout    = gold_last[WIDTH];
   assign err_sticky  = sticky_q;
   assign check_count = chk_cnt_q;
   assign err_count   = err_cnt_q;
   assign busy        = (state_q == S_FILL) || (state_q == S_CHECK);

endmodule
